// File: rtl/ultrasonic_proximity_ranger.sv
// ultrasonic_proximity_ranger
//   Drives an HC-SR04-style ultrasonic sensor. It issues a trigger pulse,
//   times the returning echo pulse and converts the width into a 4-bit
//   proximity code (15 = closest, 0 = nothing in range). It also flags
//   measurement timeouts and an echo line that is already high at trigger
//   start.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous reset, active-low
//   enable     in   1 = keep ranging; 0 = finish current measurement, then idle
//   echo       in   raw asynchronous echo pin from sensor
//   trig       out  trigger pulse to sensor
//   proximity  out  latest proximity code
//   valid      out  one-cycle pulse when proximity/timeout update
//   timeout    out  last measurement timed out (held until next valid)
//   fault      out  echo was high at a trigger start (held until reset)

module ultrasonic_proximity_ranger #(
   parameter int unsigned TRIG_CYCLES   = 32'd1000,
   parameter int unsigned STEP_CYCLES   = 32'd58000,
   parameter int unsigned ECHO_TIMEOUT  = 32'd2500000,
   parameter int unsigned PERIOD_CYCLES = 32'd6000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       echo,
   output logic       trig,
   output logic [3:0] proximity,
   output logic       valid,
   output logic       timeout,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_RISE = 3'd2,
      S_MEASURE   = 3'd3,
      S_DONE      = 3'd4,
      S_HOLDOFF   = 3'd5
   } state_t;

   // Terminal counts: a counter holding *_LAST is in its final cycle.
   localparam logic [31:0] TRIG_LAST   = TRIG_CYCLES - 32'd1;
   localparam logic [31:0] STEP_LAST   = STEP_CYCLES - 32'd1;
   localparam logic [31:0] ECHO_LAST   = ECHO_TIMEOUT - 32'd1;
   localparam logic [31:0] PERIOD_LAST = PERIOD_CYCLES - 32'd1;
   localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

   state_t      state_q, state_d;
   logic        sync1_q;
   logic        echo_s_q;
   logic        echo_prev_q;
   logic [31:0] cnt_q, cnt_d;          // trigger / wait / echo-high counter
   logic [31:0] step_cnt_q, step_cnt_d;
   logic [4:0]  steps_q, steps_d;
   logic [31:0] period_q, period_d;
   logic        trig_q, trig_d;
   logic [3:0]  prox_q, prox_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;
   logic        fault_q, fault_d;
   logic        start_s;
   logic        echo_rise_s;
   logic        echo_fall_s;

   assign echo_rise_s = echo_s_q & ~echo_prev_q;
   assign echo_fall_s = ~echo_s_q & echo_prev_q;

   // Two-flop synchroniser for the raw echo pin plus the edge-detect copy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q     <= 1'b0;
         echo_s_q    <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         sync1_q     <= echo;
         echo_s_q    <= sync1_q;
         echo_prev_q <= echo_s_q;
      end
   end

   // Next-state, counter and output computation for the ranging FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      step_cnt_d = step_cnt_q;
      steps_d    = steps_q;
      trig_d     = trig_q;
      prox_d     = prox_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;
      fault_d    = fault_q;
      start_s    = 1'b0;

      // Period counter runs from trigger start through holdoff and saturates.
      if (state_q == S_IDLE) begin
         period_d = period_q;
      end else if (period_q == CNT_MAX) begin
         period_d = period_q;
      end else begin
         period_d = period_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               start_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_TRIG: begin
            if (cnt_q >= TRIG_LAST) begin
               trig_d  = 1'b0;
               cnt_d   = 32'd0;
               state_d = S_WAIT_RISE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_WAIT_RISE: begin
            if (echo_rise_s) begin
               // The rise cycle itself is the first echo-high cycle.
               state_d    = S_MEASURE;
               cnt_d      = 32'd1;
               step_cnt_d = 32'd1;
               steps_d    = 5'd0;
            end else if (cnt_q >= ECHO_LAST) begin
               state_d   = S_DONE;
               valid_d   = 1'b1;
               prox_d    = 4'd0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_MEASURE: begin
            if (echo_fall_s) begin
               state_d   = S_DONE;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               if (steps_q >= 5'd16) begin
                  prox_d = 4'd0;
               end else begin
                  prox_d = 4'(5'd15 - steps_q);
               end
            end else if (echo_s_q) begin
               if (cnt_q >= ECHO_LAST) begin
                  state_d   = S_DONE;
                  valid_d   = 1'b1;
                  prox_d    = 4'd0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
                  if (step_cnt_q >= STEP_LAST) begin
                     step_cnt_d = 32'd0;
                     if (steps_q >= 5'd16) begin
                        steps_d = steps_q;
                     end else begin
                        steps_d = steps_q + 5'd1;
                     end
                  end else begin
                     step_cnt_d = step_cnt_q + 32'd1;
                  end
               end
            end else begin
               state_d = S_MEASURE;
            end
         end
         S_DONE: begin
            state_d = S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (period_q >= PERIOD_LAST) begin
               if (enable) begin
                  start_s = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_HOLDOFF;
            end
         end
         default: begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
         end
      endcase

      // Common trigger-start actions; fault latches if echo is already high.
      if (start_s) begin
         state_d  = S_TRIG;
         trig_d   = 1'b1;
         cnt_d    = 32'd0;
         period_d = 32'd0;
         if (echo_s_q) begin
            fault_d = 1'b1;
         end else begin
            fault_d = fault_q;
         end
      end else begin
         start_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 32'd0;
         step_cnt_q <= 32'd0;
         steps_q    <= 5'd0;
         period_q   <= 32'd0;
         trig_q     <= 1'b0;
         prox_q     <= 4'd0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_cnt_q <= step_cnt_d;
         steps_q    <= steps_d;
         period_q   <= period_d;
         trig_q     <= trig_d;
         prox_q     <= prox_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         fault_q    <= fault_d;
      end
   end

   assign trig      = trig_q;
   assign proximity = prox_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_ultrasonic_proximity_ranger.sv
// Self-checking bench for ultrasonic_proximity_ranger with shortened timing
// (TRIG=10, STEP=100, ECHO_TIMEOUT=5000, PERIOD=12000).
// Latency reference: k counts clock edges after the edge on which trig fell;
// raw echo rising at k=d and held w cycles gives valid at k=d+w+3. A missing
// echo gives valid at k=ECHO_TIMEOUT; an over-long echo at k=d+ECHO_TIMEOUT+2.

module tb_ultrasonic_proximity_ranger;

   localparam int TRIG = 10;
   localparam int STEP = 100;
   localparam int ET   = 5000;
   localparam int PER  = 12000;

   typedef struct {
      int d;
      int w;
      int prox;
      int to;
      int lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       echo;
   logic       trig;
   logic [3:0] proximity;
   logic       valid;
   logic       timeout;
   logic       fault;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_rise = 0;
   int   t1;
   int   n;
   int   highs;
   bit   found;
   vec_t vecs[9];

   ultrasonic_proximity_ranger #(
      .TRIG_CYCLES  (TRIG),
      .STEP_CYCLES  (STEP),
      .ECHO_TIMEOUT (ET),
      .PERIOD_CYCLES(PER)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .echo     (echo),
      .trig     (trig),
      .proximity(proximity),
      .valid    (valid),
      .timeout  (timeout),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   // Wait for a trigger, check its width, then play one echo pulse and
   // check the resulting valid pulse, its timing and the reported values.
   task automatic do_measure(input int d, input int w, input int exp_prox,
                             input int exp_to, input int exp_lat,
                             input bit drop_en, input string name);
      int  cnt;
      bit  seen;
      int  kmax;
      int  pulses;
      int  got_k;
      int  got_prox;
      int  got_to;
      seen = 1'b0;
      cnt  = 0;
      while (!seen && cnt < 20000) begin
         step();
         cnt++;
         if (trig) seen = 1'b1;
      end
      chk({name, "_trig_rise"}, int'(seen), 1);
      last_rise = cyc;
      echo = 1'b0;
      cnt  = 1;
      seen = 1'b0;
      while (!seen && cnt < 100) begin
         step();
         if (trig) cnt++;
         else seen = 1'b1;
      end
      chk({name, "_trig_width"}, cnt, TRIG);
      if (drop_en) enable = 1'b0;
      kmax     = (((d + w) > exp_lat) ? (d + w) : exp_lat) + 5;
      pulses   = 0;
      got_k    = -1;
      got_prox = -1;
      got_to   = -1;
      for (int k = 0; k <= kmax; k++) begin
         if (valid) begin
            pulses++;
            if (got_k < 0) begin
               got_k    = k;
               got_prox = int'(proximity);
               got_to   = int'(timeout);
            end
         end
         echo = (k >= d) && (k < d + w);
         step();
      end
      echo = 1'b0;
      chk({name, "_valid_pulses"}, pulses, 1);
      chk({name, "_latency"}, got_k, exp_lat);
      chk({name, "_proximity"}, got_prox, exp_prox);
      chk({name, "_timeout"}, got_to, exp_to);
      chk({name, "_prox_held"}, int'(proximity), exp_prox);
   endtask

   initial begin
      //            d     w    prox to  lat
      vecs[0] = '{50,   350,  12,  0, 403};
      vecs[1] = '{50,  2000,   0,  0, 2053};
      vecs[2] = '{50,    99,  15,  0, 152};
      vecs[3] = '{30,   200,  13,  0, 233};
      vecs[4] = '{10,  1499,   1,  0, 1512};
      vecs[5] = '{10,  1600,   0,  0, 1613};
      vecs[6] = '{20,  1500,   0,  0, 1523};
      vecs[7] = '{20,  6000,   0,  1, 5022};
      vecs[8] = '{40,   100,  14,  0, 143};

      reset  = 1'b0;
      enable = 1'b0;
      echo   = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      chk("rst_trig", int'(trig), 0);
      chk("rst_proximity", int'(proximity), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_fault", int'(fault), 0);
      repeat (5) step();
      chk("idle_no_trig", int'(trig), 0);

      // Table-driven single measurements, each from a fresh reset.
      for (int i = 0; i < 9; i++) begin
         enable = 1'b1;
         do_reset();
         do_measure(vecs[i].d, vecs[i].w, vecs[i].prox, vecs[i].to,
                    vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
      end

      // Echo stuck high at trigger start, then a no-echo timeout, trigger
      // period, a later good measurement, and reset during MEASURE.
      enable = 1'b0;
      do_reset();
      echo = 1'b1;
      repeat (4) step();
      enable = 1'b1;
      do_measure(0, 0, 0, 1, ET, 1'b0, "noecho");
      chk("fault_set", int'(fault), 1);
      t1 = last_rise;
      do_measure(50, 350, 12, 0, 403, 1'b0, "after_to");
      chk("trig_period", last_rise - t1, PER);
      chk("fault_sticky", int'(fault), 1);
      found = 1'b0;
      n = 0;
      while (!found && n < 20000) begin
         step();
         n++;
         if (trig) found = 1'b1;
      end
      chk("third_trig_rise", int'(found), 1);
      n = 0;
      while (trig && n < 100) begin
         step();
         n++;
      end
      repeat (10) step();
      echo = 1'b1;
      repeat (30) step();
      chk("pre_rst_prox", int'(proximity), 12);
      chk("pre_rst_fault", int'(fault), 1);
      reset = 1'b0;
      step();
      chk("midrst_trig", int'(trig), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_proximity", int'(proximity), 0);
      chk("midrst_fault", int'(fault), 0);
      chk("midrst_timeout", int'(timeout), 0);
      echo  = 1'b0;
      reset = 1'b1;
      step();
      chk("post_rst_trig", int'(trig), 1);

      // enable dropped during WAIT_RISE: measurement completes, then idle.
      enable = 1'b1;
      do_reset();
      do_measure(30, 200, 13, 0, 233, 1'b1, "en_drop");
      highs = 0;
      for (int j = 0; j < 13000; j++) begin
         step();
         if (trig) highs++;
      end
      chk("disabled_no_trig", highs, 0);
      enable = 1'b1;
      step();
      chk("reenable_trig", int'(trig), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ultrasonic_proximity_ranger.md
Name: ultrasonic_proximity_ranger

Overview:
- Drives an HC-SR04-style ultrasonic sensor (trigger pulse out, echo pulse in).
- Measures echo width and quantises it into a 4-bit proximity code, where a higher value means a closer obstacle.
- Sits directly upstream of the obstacle-avoidance FSM, whose 4-bit sensor input it drives in place of the external microcontroller.
- Also reports timeout and stuck-echo conditions.

Parameters:
- TRIG_CYCLES, 1000: trigger high width in clk cycles (10 us at 100 MHz).
- STEP_CYCLES, 58000: echo cycles per proximity step (~10 cm at 100 MHz).
- ECHO_TIMEOUT, 2500000: max cycles from trigger end to echo rise, and also the max echo-high cycles.
- PERIOD_CYCLES, 6000000: cycles from one trigger start to the next (60 ms). Must be greater than TRIG_CYCLES + 2*ECHO_TIMEOUT.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
- enable  input  1  1 = ranging runs; 0 = finish current measurement, then hold in IDLE
- echo  input  1  raw asynchronous echo pin from sensor
- trig  output  1  trigger pulse to sensor
- proximity  output  4  latest proximity code; 0 = nothing in range, 15 = closest
- valid  output  1  one-cycle pulse when proximity/timeout are updated
- timeout  output  1  1 = last measurement timed out (sticky until next valid)
- fault  output  1  1 = echo was already high at trigger start (sticky until reset)

Behaviour:
- Reset (reset==0 at a rising clk): on the next edge, state=IDLE, trig=0, proximity=0, valid=0, timeout=0, fault=0, all counters=0, sync flops=0. Applies mid-measurement too; trig drops the same edge.
- echo passes through a 2-flop synchroniser (echo_s). Edge detect compares echo_s with its registered copy. All echo decisions use echo_s only.
- State machine:
  - IDLE: if enable==1 -> TRIG. On entry to TRIG, period counter := 0. If echo_s==1 at that moment, set fault (measurement still proceeds).
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then trig=0 -> WAIT_RISE with wait counter := 0.
  - WAIT_RISE: on echo_s rising edge -> MEASURE with width counter := 0 and steps := 0. If the wait counter reaches ECHO_TIMEOUT with no rise -> DONE with timeout result.
  - MEASURE: width counter increments every cycle echo_s==1. On every STEP_CYCLES-th cycle, steps increments, saturating at 16.
    - On echo_s falling edge -> DONE with range result.
    - If echo-high cycles reach ECHO_TIMEOUT -> DONE with timeout result.
  - DONE (one cycle): valid=1.
    - Range result: proximity = (steps>=16) ? 0 : 15-steps, timeout=0.
    - Timeout result: proximity=0, timeout=1.
    - Then go to HOLDOFF.
  - HOLDOFF: wait until period counter reaches PERIOD_CYCLES-1. Then go to TRIG if enable==1, else IDLE.
- The period counter runs from TRIG entry through HOLDOFF and saturates. Trigger starts are therefore exactly PERIOD_CYCLES apart while enable stays 1.
- Latency: raw echo fall -> valid high after 3 rising edges (2 sync + 1 edge detect/DONE). proximity and timeout change on the same edge valid rises and are held stable between valid pulses.
- enable deassert mid-measurement: the current measurement completes normally (valid still pulses), then the FSM parks in IDLE. Re-assert -> TRIG on the next edge.
- Echo pulses that rise outside WAIT_RISE are ignored. An echo already high on entry to WAIT_RISE does not count as a rise.
- Counters are 32 bits, compare with >=, and never wrap.

Test Plan:
Run with TRIG_CYCLES=10, STEP_CYCLES=100, ECHO_TIMEOUT=5000, PERIOD_CYCLES=12000.
1. Reset released, enable=1, echo rises 50 cycles after trig falls and is held 350 cycles -> trig high exactly 10 cycles; valid pulses once, 3 cycles after echo falls; proximity=12, timeout=0.
2. Echo held high 2000 cycles -> steps saturate at 16 -> proximity=0, timeout=0. Echo held 99 cycles -> proximity=15.
3. No echo at all -> valid 5000 cycles after trig falls (plus latency), proximity=0, timeout=1; next trig rises exactly 12000 cycles after the previous trig rise.
4. echo tied high before the first trigger -> fault=1 and stays 1 through later good measurements until reset goes low.
5. reset driven low during MEASURE (echo high) -> next edge trig=0, proximity=0, valid=0, state IDLE; after release, a fresh trigger is issued on the following edge.
6. enable dropped during WAIT_RISE, echo 200 cycles -> valid with proximity=13, then no further trig until enable returns; trig rises 1 edge after re-enable.
